// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-wait control for the 5-stage SCPU pipeline.
// Optional saturating performance counters are enabled with `define HZD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [1:0]       dbg_state
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_mem_err;

  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_pc_stall;
  logic       w_ifid_stall;
  logic       w_ifid_flush;
  logic       w_idex_stall;
  logic       w_idex_flush;
  logic       w_exmem_stall;
  logic       w_memwb_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN && w_next_state == ST_MEM_WAIT)
        r_wait_cnt <= '0;
      else if (r_state == ST_MEM_WAIT && !dmem_ack)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_state == ST_MEM_WAIT && w_next_state == ST_ERR)
        r_mem_err <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:      if (dmem_req && !dmem_ack) w_next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (dmem_ack)                      w_next_state = ST_RUN;
        else if (r_wait_cnt == WAIT_LAST)  w_next_state = ST_ERR;
      end
      ST_ERR:      w_next_state = ST_ERR;
      default:     w_next_state = ST_RUN;
    endcase
  end

  // The ack cycle itself is not stalled: the access completes and the pipe advances.
  assign w_mem_stall = (r_state == ST_RUN      && dmem_req && !dmem_ack) ||
                       (r_state == ST_MEM_WAIT && !dmem_ack) ||
                       (r_state == ST_ERR);

  assign w_load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                       (id_uses_rs2 && id_rs2_addr == ex_rd_addr));

  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_stall = 1'b0;
    w_memwb_flush = 1'b0;
    if (w_mem_stall) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idex_stall  = 1'b1;
      w_exmem_stall = 1'b1;
      w_memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall   = 1'b1;
      w_ifid_stall = 1'b1;
      w_idex_flush = 1'b1;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == ex_rs1_addr)
      w_fwd_a = 2'b10;
    else if (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == ex_rs1_addr)
      w_fwd_a = 2'b01;
    if (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == ex_rs2_addr)
      w_fwd_b = 2'b10;
    else if (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == ex_rs2_addr)
      w_fwd_b = 2'b01;
  end

  // Combinational outputs are forced low while reset is held.
  assign pc_stall    = w_pc_stall    & rstn;
  assign ifid_stall  = w_ifid_stall  & rstn;
  assign ifid_flush  = w_ifid_flush  & rstn;
  assign idex_stall  = w_idex_stall  & rstn;
  assign idex_flush  = w_idex_flush  & rstn;
  assign exmem_stall = w_exmem_stall & rstn;
  assign memwb_flush = w_memwb_flush & rstn;
  assign fwd_a       = w_fwd_a & {2{rstn}};
  assign fwd_b       = w_fwd_b & {2{rstn}};
  assign mem_err     = r_mem_err;
  assign dbg_state   = r_state;

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall_cnt;
  logic [CNT_W-1:0] r_perf_flush_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && r_perf_stall_cnt != {CNT_W{1'b1}})
        r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
      if (w_ifid_flush && r_perf_flush_cnt != {CNT_W{1'b1}})
        r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch, forwarding, memory wait,
// timeout and asynchronous reset, checked against an expected-value queue.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_LU   = 7'b1100100;
  localparam logic [6:0] CTL_BR   = 7'b0010100;
  localparam logic [6:0] CTL_MEM  = 7'b1101011;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;

  logic       clk;
  logic       rstn;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [4:0] mem_rd_addr, wb_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, wb_reg_write, dmem_req, dmem_ack;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, memwb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b, dbg_state;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  logic [13:0] exp_q[$];
  logic [13:0] obs;
  int          errors = 0;
  int          checks = 0;
  int          exp_stall_cnt = 0;
  int          exp_flush_cnt = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .dbg_state(dbg_state)
`ifdef HZD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
                memwb_flush, fwd_a, fwd_b, mem_err, dbg_state};

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no end of test required=finish before 200us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [13:0] ev(input logic [6:0] c, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic me,
                                     input logic [1:0] st);
    return {c, fa, fb, me, st};
  endfunction

  task automatic clear_inputs();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rd_addr = 0;
    mem_rd_addr = 0; wb_rd_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare: expected pushed with the stimulus, popped at the sample point.
  task automatic check(input string tag, input logic [13:0] exp, input bit now);
    logic [13:0] want;
    exp_q.push_back(exp);
    if (now) #1;
    else @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (want[13]) exp_stall_cnt++;
    if (want[11]) exp_flush_cnt++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%b required=%b", tag, obs, want);
    end
  endtask

  task automatic step(input string tag, input logic [13:0] exp);
    check(tag, exp, 1'b0);
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    mem_reg_write = 1; mem_rd_addr = 7; ex_rs1_addr = 7;
    ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1; dmem_req = 1;
    #3;
    check("reset_outputs", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN), 1'b1);
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    step("idle", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));

    // load-use
    ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1;
    step("lu_rs1", ev(CTL_LU, 2'b00, 2'b00, 1'b0, S_RUN));
    ex_mem_read = 0;
    step("lu_release", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    ex_mem_read = 1; id_uses_rs1 = 0;
    step("lu_rs1_unused", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    id_uses_rs1 = 1; ex_rd_addr = 0; id_rs1_addr = 0;
    step("lu_rd_zero", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    ex_rd_addr = 9; id_rs2_addr = 9; id_uses_rs2 = 1; id_rs1_addr = 5;
    step("lu_rs2", ev(CTL_LU, 2'b00, 2'b00, 1'b0, S_RUN));
    ex_branch_taken = 1;
    step("branch_over_lu", ev(CTL_BR, 2'b00, 2'b00, 1'b0, S_RUN));
    clear_inputs();

    // forwarding
    mem_rd_addr = 7; wb_rd_addr = 7; mem_reg_write = 1; wb_reg_write = 1;
    ex_rs1_addr = 7; ex_rs2_addr = 3;
    step("fwd_a_exmem", ev(CTL_NONE, 2'b10, 2'b00, 1'b0, S_RUN));
    mem_reg_write = 0;
    step("fwd_a_memwb", ev(CTL_NONE, 2'b01, 2'b00, 1'b0, S_RUN));
    mem_reg_write = 1; mem_rd_addr = 0; wb_rd_addr = 0; ex_rs1_addr = 0;
    step("fwd_a_rd_zero", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    mem_rd_addr = 3; wb_rd_addr = 7; ex_rs1_addr = 7; ex_rs2_addr = 3;
    step("fwd_mixed", ev(CTL_NONE, 2'b01, 2'b10, 1'b0, S_RUN));
    clear_inputs();

    // memory wait with ack on the fourth cycle
    dmem_req = 1;
    step("mw_cycle1", ev(CTL_MEM, 2'b00, 2'b00, 1'b0, S_RUN));
    step("mw_cycle2", ev(CTL_MEM, 2'b00, 2'b00, 1'b0, S_MW));
    ex_branch_taken = 1; mem_reg_write = 1; mem_rd_addr = 4; ex_rs1_addr = 4;
    step("mw_cycle3_fwd_br", ev(CTL_MEM, 2'b10, 2'b00, 1'b0, S_MW));
    ex_branch_taken = 0; mem_reg_write = 0; mem_rd_addr = 0; ex_rs1_addr = 0;
    dmem_ack = 1;
    step("mw_ack", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_MW));
    dmem_req = 0; dmem_ack = 0;
    step("mw_back_run", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    dmem_req = 1; dmem_ack = 1;
    step("req_ack_same", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));
    dmem_req = 0; dmem_ack = 0;
    step("after_same", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));

`ifdef HZD_PERF_CNT_EN
    checks++;
    assert (perf_stall_cnt === 32'(exp_stall_cnt)) else begin
      errors++;
      $error("FAIL perf_stall_cnt: observed=%0d required=%0d", perf_stall_cnt, exp_stall_cnt);
    end
    checks++;
    assert (perf_flush_cnt === 32'(exp_flush_cnt)) else begin
      errors++;
      $error("FAIL perf_flush_cnt: observed=%0d required=%0d", perf_flush_cnt, exp_flush_cnt);
    end
`endif

    // timeout: one RUN stall cycle, then 16 MEM_WAIT cycles, then ERR
    dmem_req = 1;
    for (int i = 0; i < 17; i++)
      step("timeout_wait", ev(CTL_MEM, 2'b00, 2'b00, 1'b0, (i == 0) ? S_RUN : S_MW));
    step("timeout_err", ev(CTL_MEM, 2'b00, 2'b00, 1'b1, S_ERR));
    dmem_req = 0;
    step("err_hold_noreq", ev(CTL_MEM, 2'b00, 2'b00, 1'b1, S_ERR));
    dmem_ack = 1;
    step("err_hold_ack", ev(CTL_MEM, 2'b00, 2'b00, 1'b1, S_ERR));
    mem_reg_write = 1; mem_rd_addr = 7; ex_rs1_addr = 7;
    #2;
    rstn = 1'b0;
    check("async_reset_in_err", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN), 1'b1);
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    step("post_reset_run", ev(CTL_NONE, 2'b00, 2'b00, 1'b0, S_RUN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
